// File: rtl/sa_cache_ctrl.sv
// Set-associative cache controller: zero-wait hits, optional dirty-victim
// writeback burst, line fill burst, and a single completion cycle.
// Hits are answered combinationally in IDLE. All outputs are gated by rst_n
// so nothing can strobe while reset is held.
module sa_cache_ctrl #(
  parameter int BLOCK_WORDS = 4,
  parameter int WIDX_W      = $clog2(BLOCK_WORDS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [3:0]        hit_vec,
  input  logic [1:0]        lru_way,
  input  logic              victim_valid,
  input  logic              victim_dirty,
  input  logic              mem_ack,
  output logic              cpu_ack,
  output logic              lru_we,
  output logic [1:0]        lru_in,
  output logic [1:0]        way_sel,
  output logic [WIDX_W-1:0] word_idx,
  output logic              mem_wr_req,
  output logic              mem_rd_req,
  output logic              fill_we,
  output logic              tag_we,
  output logic              dirty_set,
  output logic              dirty_clr,
  output logic              busy,
  output logic              multi_hit
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WB   = 2'd1;
  localparam logic [1:0] S_FILL = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [WIDX_W-1:0] LAST_WORD = WIDX_W'(BLOCK_WORDS - 1);
  localparam logic [WIDX_W-1:0] ONE_WORD  = WIDX_W'(1);

  // Index of the lowest set bit; only meaningful when at least one bit is set.
  function automatic logic [1:0] lowest_hit(input logic [3:0] v);
    logic [1:0] idx;
    if (v[0]) begin
      idx = 2'd0;
    end else if (v[1]) begin
      idx = 2'd1;
    end else if (v[2]) begin
      idx = 2'd2;
    end else begin
      idx = 2'd3;
    end
    return idx;
  endfunction

  // True when more than one way claims a hit (clearing the lowest bit leaves a bit set).
  function automatic logic many_hits(input logic [3:0] v);
    return ((v & (v - 4'd1)) != 4'd0);
  endfunction

  logic [1:0]        state_q,     state_d;
  logic [1:0]        victim_q,    victim_d;
  logic [WIDX_W-1:0] cnt_q,       cnt_d;
  logic              multi_hit_q, multi_hit_d;

  logic              cpu_ack_s, lru_we_s, mem_wr_req_s, mem_rd_req_s;
  logic              fill_we_s, tag_we_s, dirty_set_s, dirty_clr_s, busy_s;
  logic [1:0]        lru_in_s, way_sel_s;
  logic [WIDX_W-1:0] word_idx_s;
  logic              last_word_s;

  assign last_word_s = (cnt_q == LAST_WORD);

  // Next-state, counter and victim update plus per-state output decode.
  always_comb begin
    state_d      = state_q;
    victim_d     = victim_q;
    cnt_d        = cnt_q;
    multi_hit_d  = multi_hit_q;
    cpu_ack_s    = 1'b0;
    lru_we_s     = 1'b0;
    lru_in_s     = 2'd0;
    way_sel_s    = 2'd0;
    word_idx_s   = '0;
    mem_wr_req_s = 1'b0;
    mem_rd_req_s = 1'b0;
    fill_we_s    = 1'b0;
    tag_we_s     = 1'b0;
    dirty_set_s  = 1'b0;
    dirty_clr_s  = 1'b0;
    busy_s       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cpu_req) begin
          if (hit_vec != 4'd0) begin
            // Zero-wait hit: acknowledge and touch LRU in the request cycle.
            cpu_ack_s   = 1'b1;
            lru_we_s    = 1'b1;
            lru_in_s    = lowest_hit(hit_vec);
            way_sel_s   = lowest_hit(hit_vec);
            dirty_set_s = cpu_we;
            if (many_hits(hit_vec)) begin
              multi_hit_d = 1'b1;
            end else begin
              multi_hit_d = multi_hit_q;
            end
          end else begin
            // Miss: remember the victim now, the LRU inputs may move later.
            victim_d = lru_way;
            cnt_d    = '0;
            if (victim_valid && victim_dirty) begin
              state_d = S_WB;
            end else begin
              state_d = S_FILL;
            end
          end
        end else begin
          state_d = S_IDLE;
        end
      end

      S_WB: begin
        busy_s       = 1'b1;
        mem_wr_req_s = 1'b1;
        way_sel_s    = victim_q;
        word_idx_s   = cnt_q;
        if (mem_ack) begin
          if (last_word_s) begin
            cnt_d   = '0;
            state_d = S_FILL;
          end else begin
            cnt_d = cnt_q + ONE_WORD;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end

      S_FILL: begin
        busy_s       = 1'b1;
        mem_rd_req_s = 1'b1;
        way_sel_s    = victim_q;
        word_idx_s   = cnt_q;
        fill_we_s    = mem_ack;
        if (mem_ack) begin
          if (last_word_s) begin
            // Last word lands together with the new tag; the line starts clean.
            tag_we_s    = 1'b1;
            dirty_clr_s = 1'b1;
            cnt_d       = '0;
            state_d     = S_DONE;
          end else begin
            cnt_d = cnt_q + ONE_WORD;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end

      S_DONE: begin
        // Complete the original access against the freshly filled way.
        busy_s      = 1'b1;
        cpu_ack_s   = 1'b1;
        lru_we_s    = 1'b1;
        lru_in_s    = victim_q;
        way_sel_s   = victim_q;
        dirty_set_s = cpu_we;
        state_d     = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State, victim, word counter and sticky multi-hit registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      victim_q    <= 2'd0;
      cnt_q       <= '0;
      multi_hit_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      victim_q    <= victim_d;
      cnt_q       <= cnt_d;
      multi_hit_q <= multi_hit_d;
    end
  end

  // Reset gating keeps every strobe low for as long as rst_n is held,
  // even while a hit is being presented on the inputs.
  assign cpu_ack    = cpu_ack_s    & rst_n;
  assign lru_we     = lru_we_s     & rst_n;
  assign lru_in     = lru_in_s     & {2{rst_n}};
  assign way_sel    = way_sel_s    & {2{rst_n}};
  assign word_idx   = word_idx_s   & {WIDX_W{rst_n}};
  assign mem_wr_req = mem_wr_req_s & rst_n;
  assign mem_rd_req = mem_rd_req_s & rst_n;
  assign fill_we    = fill_we_s    & rst_n;
  assign tag_we     = tag_we_s     & rst_n;
  assign dirty_set  = dirty_set_s  & rst_n;
  assign dirty_clr  = dirty_clr_s  & rst_n;
  assign busy       = busy_s       & rst_n;
  assign multi_hit  = multi_hit_q;

endmodule

// File: tb/tb_sa_cache_ctrl.sv
// Scoreboard bench for sa_cache_ctrl: stimulus pushes the expected output
// vector for every cycle the controller should be active; a negedge monitor
// pops and compares whenever the controller shows any activity.
module tb_sa_cache_ctrl;

  logic       clk;
  logic       rst_n;
  logic       cpu_req, cpu_we, victim_valid, victim_dirty, mem_ack;
  logic [3:0] hit_vec;
  logic [1:0] lru_way;
  logic       cpu_ack, lru_we, mem_wr_req, mem_rd_req, fill_we, tag_we;
  logic       dirty_set, dirty_clr, busy, multi_hit;
  logic [1:0] lru_in, way_sel, word_idx;

  // Eight-word build, exercised separately.
  logic       req8, we8, vv8, vd8, ack8;
  logic [3:0] hv8;
  logic [1:0] lw8;
  logic       cpu_ack8, lru_we8, wr8, rd8, fill_we8, tag_we8;
  logic       ds8, dc8, busy8, mh8;
  logic [1:0] lru_in8, way_sel8;
  logic [2:0] widx8;

  int checks   = 0;
  int failures = 0;
  logic [15:0] exp_q[$];

  sa_cache_ctrl u_dut (
    .clk(clk), .rst_n(rst_n), .cpu_req(cpu_req), .cpu_we(cpu_we),
    .hit_vec(hit_vec), .lru_way(lru_way), .victim_valid(victim_valid),
    .victim_dirty(victim_dirty), .mem_ack(mem_ack), .cpu_ack(cpu_ack),
    .lru_we(lru_we), .lru_in(lru_in), .way_sel(way_sel), .word_idx(word_idx),
    .mem_wr_req(mem_wr_req), .mem_rd_req(mem_rd_req), .fill_we(fill_we),
    .tag_we(tag_we), .dirty_set(dirty_set), .dirty_clr(dirty_clr),
    .busy(busy), .multi_hit(multi_hit)
  );

  sa_cache_ctrl #(.BLOCK_WORDS(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .cpu_req(req8), .cpu_we(we8),
    .hit_vec(hv8), .lru_way(lw8), .victim_valid(vv8),
    .victim_dirty(vd8), .mem_ack(ack8), .cpu_ack(cpu_ack8),
    .lru_we(lru_we8), .lru_in(lru_in8), .way_sel(way_sel8), .word_idx(widx8),
    .mem_wr_req(wr8), .mem_rd_req(rd8), .fill_we(fill_we8),
    .tag_we(tag_we8), .dirty_set(ds8), .dirty_clr(dc8),
    .busy(busy8), .multi_hit(mh8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] mk(
    input logic b, input logic a, input logic lw, input logic [1:0] li,
    input logic [1:0] ws, input logic [1:0] wi, input logic wr, input logic rd,
    input logic fw, input logic tw, input logic ds, input logic dc, input logic mh);
    return {b, a, lw, li, ws, wi, wr, rd, fw, tw, ds, dc, mh};
  endfunction

  logic [15:0] got_s;
  logic        active_s;
  assign got_s = {busy, cpu_ack, lru_we, lru_in, way_sel, word_idx,
                  mem_wr_req, mem_rd_req, fill_we, tag_we, dirty_set, dirty_clr, multi_hit};
  assign active_s = busy | cpu_ack | lru_we | mem_wr_req | mem_rd_req |
                    fill_we | tag_we | dirty_set | dirty_clr;

  // Monitor: every active cycle must match the next queued expectation.
  always @(negedge clk) begin
    logic [15:0] e;
    if (rst_n && active_s) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_activity got=%h required=none", got_s);
      end else begin
        e = exp_q.pop_front();
        if (got_s !== e) begin
          failures++;
          $display("FAIL cycle_outputs got=%h required=%h (busy,ack,lru_we,lru_in,way,widx,wr,rd,fwe,twe,ds,dc,mh)", got_s, e);
        end
      end
    end
  end

  task automatic drv(input logic req, input logic we, input logic [3:0] hv,
                     input logic [1:0] lw, input logic vv, input logic vd, input logic ma);
    @(posedge clk);
    #1;
    cpu_req = req; cpu_we = we; hit_vec = hv; lru_way = lw;
    victim_valid = vv; victim_dirty = vd; mem_ack = ma;
  endtask

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] req);
    checks++;
    if (got !== req) begin
      failures++;
      $display("FAIL %s got=%h required=%h", name, got, req);
    end
  endtask

  int n_wr8, n_rd8;
  logic done8;

  initial begin
    rst_n = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b1; hit_vec = 4'b0001; lru_way = 2'd0;
    victim_valid = 1'b0; victim_dirty = 1'b0; mem_ack = 1'b1;
    req8 = 1'b0; we8 = 1'b0; hv8 = 4'd0; lw8 = 2'd0; vv8 = 1'b0; vd8 = 1'b0; ack8 = 1'b0;

    // Reset state: a hit presented during reset must not strobe anything.
    @(negedge clk);
    chk("reset_outputs", got_s, 16'h0000);
    @(posedge clk); #1;
    cpu_req = 1'b0; hit_vec = 4'd0; mem_ack = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Idle with stray mem_ack: no activity.
    drv(1'b0, 1'b0, 4'd0, 2'd0, 1'b0, 1'b0, 1'b1);
    drv(1'b0, 1'b0, 4'd0, 2'd0, 1'b0, 1'b0, 1'b1);

    // Store hit on way 2.
    drv(1'b1, 1'b1, 4'b0100, 2'd0, 1'b0, 1'b0, 1'b0);
    exp_q.push_back(mk(1'b0, 1'b1, 1'b1, 2'd2, 2'd2, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
    drv(1'b0, 1'b0, 4'd0, 2'd0, 1'b0, 1'b0, 1'b0);

    // Clean miss into way 3, mem_ack every cycle.
    drv(1'b1, 1'b0, 4'd0, 2'd3, 1'b1, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      drv(1'b1, 1'b0, 4'd0, 2'd3, 1'b1, 1'b0, 1'b1);
      exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 2'd0, 2'd3, 2'(k), 1'b0, 1'b1, 1'b1,
                         (k == 3), 1'b0, (k == 3), 1'b0));
    end
    drv(1'b1, 1'b0, 4'd0, 2'd3, 1'b1, 1'b0, 1'b1);
    exp_q.push_back(mk(1'b1, 1'b1, 1'b1, 2'd3, 2'd3, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    drv(1'b0, 1'b0, 4'd0, 2'd0, 1'b0, 1'b0, 1'b0);

    // Dirty store miss on way 1, mem_ack every other cycle.
    drv(1'b1, 1'b1, 4'd0, 2'd1, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      drv(1'b1, 1'b1, 4'd0, 2'd1, 1'b1, 1'b1, 1'(i % 2));
      exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 2'd0, 2'd1, 2'(i / 2), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    end
    for (int i = 0; i < 8; i++) begin
      drv(1'b1, 1'b1, 4'd0, 2'd1, 1'b1, 1'b1, 1'(i % 2));
      exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 2'd0, 2'd1, 2'(i / 2), 1'b0, 1'b1, 1'(i % 2),
                         (i == 7), 1'b0, (i == 7), 1'b0));
    end
    drv(1'b1, 1'b1, 4'd0, 2'd1, 1'b1, 1'b1, 1'b0);
    exp_q.push_back(mk(1'b1, 1'b1, 1'b1, 2'd1, 2'd1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
    drv(1'b0, 1'b0, 4'd0, 2'd0, 1'b0, 1'b0, 1'b0);

    // Multi-hit: lowest way wins, flag becomes sticky from the next cycle.
    drv(1'b1, 1'b0, 4'b1010, 2'd0, 1'b0, 1'b0, 1'b0);
    exp_q.push_back(mk(1'b0, 1'b1, 1'b1, 2'd1, 2'd1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    drv(1'b0, 1'b0, 4'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("multi_hit_sticky", {15'd0, multi_hit}, 16'h0001);
    drv(1'b1, 1'b0, 4'b1000, 2'd0, 1'b0, 1'b0, 1'b0);
    exp_q.push_back(mk(1'b0, 1'b1, 1'b1, 2'd3, 2'd3, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
    drv(1'b0, 1'b0, 4'd0, 2'd0, 1'b0, 1'b0, 1'b0);

    // Miss into invalid way 2, reset after two filled words.
    drv(1'b1, 1'b0, 4'd0, 2'd2, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 2; k++) begin
      drv(1'b1, 1'b0, 4'd0, 2'd2, 1'b0, 1'b0, 1'b1);
      exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 2'd0, 2'd2, 2'(k), 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1));
    end
    @(posedge clk); #1;
    rst_n = 1'b0;
    hit_vec = 4'b0001;
    @(negedge clk);
    chk("reset_mid_fill", got_s, 16'h0000);
    @(posedge clk); #1;
    cpu_req = 1'b0; hit_vec = 4'd0; mem_ack = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    drv(1'b1, 1'b0, 4'd0, 2'd2, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      drv(1'b1, 1'b0, 4'd0, 2'd2, 1'b0, 1'b0, 1'b1);
      exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 2'd0, 2'd2, 2'(k), 1'b0, 1'b1, 1'b1,
                         (k == 3), 1'b0, (k == 3), 1'b0));
    end
    drv(1'b1, 1'b0, 4'd0, 2'd2, 1'b0, 1'b0, 1'b1);
    exp_q.push_back(mk(1'b1, 1'b1, 1'b1, 2'd2, 2'd2, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    drv(1'b0, 1'b0, 4'd0, 2'd0, 1'b0, 1'b0, 1'b0);

    // Eight-word build: dirty miss, mem_ack every cycle.
    @(posedge clk); #1;
    req8 = 1'b1; lw8 = 2'd2; vv8 = 1'b1; vd8 = 1'b1; ack8 = 1'b1;
    n_wr8 = 0; n_rd8 = 0; done8 = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (wr8 && ack8) n_wr8++;
      if (rd8 && ack8) n_rd8++;
      if (cpu_ack8) begin
        done8 = 1'b1;
        break;
      end
    end
    @(posedge clk); #1;
    req8 = 1'b0; ack8 = 1'b0;
    chk("bw8_ack_seen", {15'd0, done8}, 16'h0001);
    chk("bw8_wb_beats", 16'(n_wr8), 16'd8);
    chk("bw8_fill_beats", 16'(n_rd8), 16'd8);

    // All queued expectations must have been consumed.
    for (int c = 0; c < 4; c++) @(posedge clk);
    @(negedge clk);
    chk("queue_drained", 16'(exp_q.size()), 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sa_cache_ctrl.md
SA_CACHE_CTRL -- requirements
Module: sa_cache_ctrl

Interface
REQ-001 Parameter BLOCK_WORDS, default 4, words per cache line; legal values are 2, 4 and 8.
REQ-002 Parameter WIDX_W, default $clog2(BLOCK_WORDS), width of word_idx.
REQ-003 CLK  in  1  sole clock; all state is updated on the posedge.
REQ-004 RST_N  in  1  reset; asynchronous, active-low.
REQ-005 cpu_req  in  1  CPU access valid; held until cpu_ack.
REQ-006 cpu_we  in  1  access is a store; stable while cpu_req is high.
REQ-007 hit_vec  in  4  per-way tag-match-and-valid vector for the current index.
REQ-008 lru_way  in  2  least-recently-used way, from the LRU priority queue.
REQ-009 victim_valid  in  1  valid bit of way lru_way.
REQ-010 victim_dirty  in  1  dirty bit of way lru_way.
REQ-011 mem_ack  in  1  memory accepted or returned one word this cycle.
REQ-012 cpu_ack  out  1  access complete, one-cycle pulse.
REQ-013 lru_we  out  1  write strobe to the LRU priority queue.
REQ-014 lru_in  out  2  way to mark most-recently-used.
REQ-015 way_sel  out  2  way addressed by the data/tag arrays.
REQ-016 word_idx  out  WIDX_W  word within the line for burst transfers.
REQ-017 mem_wr_req / mem_rd_req  out  1 each  writeback / fill burst request.
REQ-018 fill_we, tag_we, dirty_set, dirty_clr  out  1 each  array write strobes.
REQ-019 busy  out  1  miss handling in progress.
REQ-020 multi_hit  out  1  sticky error flag, set when hit_vec has more than one bit set.

Function
REQ-021 FSM states SHALL be IDLE, WB, FILL and DONE, encoded 2 bits; registered victim (2b) and word counter (WIDX_W) are held alongside.
REQ-022 IDLE, cpu_req=1, hit_vec!=0 (hit): in the same cycle cpu_ack=1, lru_we=1, lru_in=way_sel=index of the lowest set hit_vec bit, dirty_set=cpu_we; the FSM stays in IDLE, giving zero-wait hits.
REQ-023 IDLE, cpu_req=1, hit_vec==0 (miss): latch victim<=lru_way and clear the counter; go to WB if victim_valid&victim_dirty, else go to FILL.
REQ-024 WB: mem_wr_req=1, way_sel=victim, word_idx=counter; on each mem_ack the counter increments; on mem_ack with counter==BLOCK_WORDS-1, clear the counter and go to FILL.
REQ-025 FILL: mem_rd_req=1, way_sel=victim, word_idx=counter, fill_we=mem_ack.
REQ-026 FILL, on mem_ack with the last word: tag_we=1 and dirty_clr=1 in that cycle, then go to DONE.
REQ-027 DONE (exactly one cycle): cpu_ack=1, lru_we=1, lru_in=way_sel=victim, dirty_set=cpu_we; then go to IDLE.
REQ-028 mem_ack SHALL be ignored in IDLE and DONE; with no mem_ack the FSM waits indefinitely in WB or FILL.
REQ-029 busy=1 in WB, FILL and DONE.
REQ-030 lru_we SHALL be a full-cycle pulse, so the negedge-updated LRU queue samples it mid-cycle.
REQ-031 lru_we SHALL never be asserted in WB or FILL.
REQ-032 multi_hit SHALL be set on any IDLE hit with popcount(hit_vec)>1 and cleared only by reset; that hit still proceeds per REQ-022.
REQ-033 Word counter SHALL wrap only through the explicit clear in REQ-024; it never exceeds BLOCK_WORDS-1.
REQ-034 cpu_req low in IDLE SHALL produce no strobes.

Reset
REQ-035 RST_N low SHALL immediately force IDLE, counter=0, victim=0, multi_hit=0 and every output 0, including mid-WB and mid-FILL; a burst in flight is abandoned and no strobe glitches.
REQ-036 After RST_N deasserts, the first possible action SHALL occur at the next posedge.

Verification
REQ-037 Hit: hit_vec=4'b0100, cpu_we=1 -> same cycle cpu_ack=1, lru_we=1, lru_in=2, dirty_set=1, busy=0.
REQ-038 Clean miss: hit_vec=0, lru_way=3, victim_valid=1, victim_dirty=0, mem_ack every cycle -> FILL word_idx 0..3, fill_we x4, tag_we with word 3, DONE with cpu_ack=1, lru_in=3; 6 cycles from request to ack.
REQ-039 Dirty miss with mem_ack every other cycle: lru_way=1, victim_dirty=1 -> 4 mem_wr_req beats (word_idx 0..3) then 4 fill beats, all on way 1; lru_we only in DONE.
REQ-040 Multi-hit: hit_vec=4'b1010 -> way_sel=1, multi_hit=1, which stays 1 through later traffic until RST_N.
REQ-041 Reset mid-FILL after 2 words -> outputs 0 during reset; the next miss restarts at word_idx=0.
REQ-042 BLOCK_WORDS=8 build: a dirty miss yields exactly 8 writeback and 8 fill acks before cpu_ack.
